// File: rtl/issue_scheduler.sv
// issue_scheduler: single-word issue head, per-unit latency tracking, register scoreboard and
// lowest-opcode-first writeback arbiter. Define SCHED_PERF_EN to enable the stall counter.
module issue_scheduler #(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 3,
    parameter int LAT_LONG   = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [17:0]      instr,
    output logic             instr_ready,
    output logic             issue_valid,
    output logic [7:0]       issue_op,
    output logic             issue_sv,
    output logic [4:0]       issue_raddr,
    output logic [1:0]       issue_ram,
    output logic [4:0]       issue_waddr,
    output logic [1:0]       issue_wam,
    output logic             wb_valid,
    output logic             wb_sv,
    output logic [4:0]       wb_addr,
    output logic [7:0]       unit_busy,
    output logic             idle,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {U_FREE = 2'd0, U_RUN = 2'd1, U_DONE = 2'd2} unit_state_t;

    logic             head_valid_r;
    logic [17:0]      head_r;
    logic [1:0][31:0] sb_r;
    unit_state_t      ust_r [8];
    unit_state_t      ust_s [8];
    logic [7:0]       ucnt_r [8];
    logic [7:0]       ucnt_s [8];
    logic [4:0]       uaddr_r [8];
    logic [7:0]       usv_r;
    logic [7:0]       busy_s;
    logic [7:0]       done_s;
    logic [2:0]       grant_s;
    logic             grant_valid_s;
    logic             issue_go_s;

    logic       head_sv_s;
    logic [2:0] head_opc_s;
    logic [4:0] head_raddr_s;
    logic [4:0] head_waddr_s;

    function automatic logic [7:0] lat_of(input logic [2:0] opc);
        case (opc)
            3'd2:              lat_of = 8'(LAT_MUL);
            3'd5, 3'd6, 3'd7:  lat_of = 8'(LAT_LONG);
            default:           lat_of = 8'(LAT_SIMPLE);
        endcase
    endfunction

    assign head_sv_s    = head_r[17];
    assign head_opc_s   = head_r[16:14];
    assign head_raddr_s = head_r[9:5];
    assign head_waddr_s = head_r[4:0];

    // Hazard check reads only the registered scoreboard; no bypass from writeback.
    assign issue_go_s  = head_valid_r & ~busy_s[head_opc_s]
                       & ~sb_r[head_sv_s][head_raddr_s] & ~sb_r[head_sv_s][head_waddr_s];
    assign instr_ready = ~head_valid_r | issue_go_s;
    assign idle        = ~head_valid_r & ~(|busy_s);
    assign unit_busy   = busy_s;

    // Per-unit busy and done flags decoded from the unit state machines.
    always_comb begin
        busy_s = 8'd0;
        done_s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            busy_s[i] = (ust_r[i] != U_FREE);
            done_s[i] = (ust_r[i] == U_DONE);
        end
    end

    // Writeback arbiter: scan from the top so the lowest DONE opcode is the last to win.
    always_comb begin
        grant_valid_s = |done_s;
        grant_s       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (done_s[i]) begin
                grant_s = 3'(i);
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Unit FSM next state: FREE -> RUN -> DONE -> FREE, single-cycle ops go straight to DONE.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ust_s[i]  = ust_r[i];
            ucnt_s[i] = ucnt_r[i];
            case (ust_r[i])
                U_FREE: begin
                    if (issue_go_s && (head_opc_s == 3'(i))) begin
                        ucnt_s[i] = lat_of(head_opc_s);
                        ust_s[i]  = (lat_of(head_opc_s) <= 8'd1) ? U_DONE : U_RUN;
                    end else begin
                        ust_s[i] = U_FREE;
                    end
                end
                U_RUN: begin
                    ucnt_s[i] = ucnt_r[i] - 8'd1;
                    if (ucnt_r[i] <= 8'd2) begin
                        ust_s[i] = U_DONE;
                    end else begin
                        ust_s[i] = U_RUN;
                    end
                end
                U_DONE: begin
                    if (grant_valid_s && (grant_s == 3'(i))) begin
                        ust_s[i] = U_FREE;
                    end else begin
                        ust_s[i] = U_DONE;
                    end
                end
                default: ust_s[i] = U_FREE;
            endcase
        end
    end

    // Head register, issue/writeback outputs, scoreboard and unit state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_r <= 1'b0;
            head_r       <= 18'd0;
            sb_r         <= '0;
            issue_valid  <= 1'b0;
            issue_op     <= 8'd0;
            issue_sv     <= 1'b0;
            issue_raddr  <= 5'd0;
            issue_ram    <= 2'd0;
            issue_waddr  <= 5'd0;
            issue_wam    <= 2'd0;
            wb_valid     <= 1'b0;
            wb_sv        <= 1'b0;
            wb_addr      <= 5'd0;
            usv_r        <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                ust_r[i]   <= U_FREE;
                ucnt_r[i]  <= 8'd0;
                uaddr_r[i] <= 5'd0;
            end
        end else begin
            if (instr_valid && instr_ready) begin
                head_valid_r <= 1'b1;
                head_r       <= instr;
            end else if (issue_go_s) begin
                head_valid_r <= 1'b0;
            end
            issue_valid <= issue_go_s;
            if (issue_go_s) begin
                issue_op              <= 8'd1 << head_opc_s;
                issue_sv              <= head_sv_s;
                issue_raddr           <= head_raddr_s;
                issue_ram             <= head_r[13:12];
                issue_waddr           <= head_waddr_s;
                issue_wam             <= head_r[11:10];
                uaddr_r[head_opc_s]   <= head_waddr_s;
                usv_r[head_opc_s]     <= head_sv_s;
            end
            wb_valid <= grant_valid_s;
            if (grant_valid_s) begin
                wb_sv   <= usv_r[grant_s];
                wb_addr <= uaddr_r[grant_s];
            end
            // Release the register while its writeback pulse is out, so dependents issue at wb+2.
            if (wb_valid) begin
                sb_r[wb_sv][wb_addr] <= 1'b0;
            end
            if (issue_go_s) begin
                sb_r[head_sv_s][head_waddr_s] <= 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                ust_r[i]  <= ust_s[i];
                ucnt_r[i] <= ucnt_s[i];
            end
        end
    end

`ifdef SCHED_PERF_EN
    // Saturating count of cycles in which a valid head word was held back.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (head_valid_r && !issue_go_s && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule
